// File: rtl/expr_datapath.sv
// Operand capture, register-transfer datapath and result handshake for the
// expression solver; executes one micro-op per cycle under sequencer command.
module expr_datapath #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic [W-1:0] c_in,
  input  logic [W-1:0] x_in,
  output logic         start,
  input  logic         LX,
  input  logic         LS,
  input  logic         LH,
  input  logic         H,
  input  logic [1:0]   M0,
  input  logic [1:0]   M1,
  input  logic [1:0]   M2,
  input  logic         completed,
  output logic         ctrl_clr,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] a_q, b_q, c_q, xin_q;
  logic [W-1:0] rx_q, rs_q, rh_q;
  logic [W-1:0] out_data_q;
  logic         out_valid_q, ctrl_clr_q;
  logic [W-1:0] coef, op_a, op_b, alu;
  logic         accept;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)    state_d = S_START;
      S_START:                state_d = S_RUN;
      S_RUN:   if (completed) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // A new operand set is refused until the sequencer has dropped completed
  always_comb begin
    in_ready = (state_q == S_IDLE) && !completed;
    start    = (state_q == S_START);
  end

  assign accept    = in_valid && in_ready;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign ctrl_clr  = ctrl_clr_q;

  always_comb begin
    case (M0)
      2'b00:   coef = '0;
      2'b01:   coef = a_q;
      2'b10:   coef = b_q;
      default: coef = c_q;
    endcase
    case (M1)
      2'b00:   op_a = rs_q;
      2'b01:   op_a = rx_q;
      2'b10:   op_a = coef;
      default: op_a = rh_q;
    endcase
    case (M2)
      2'b00:   op_b = rx_q;
      2'b01:   op_b = coef;
      2'b10:   op_b = rh_q;
      default: op_b = rs_q;
    endcase
    alu = H ? W'(op_a * op_b) : W'(op_a + op_b);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      xin_q       <= '0;
      rx_q        <= '0;
      rs_q        <= '0;
      rh_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ctrl_clr_q  <= 1'b0;
    end else begin
      ctrl_clr_q <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          a_q   <= a_in;
          b_q   <= b_in;
          c_q   <= c_in;
          xin_q <= x_in;
        end
        S_START: begin
          rx_q <= '0;
          rs_q <= '0;
          rh_q <= '0;
        end
        S_RUN: begin
          if (LX) rx_q <= xin_q;
          if (LS) rs_q <= alu;
          if (LH) rh_q <= alu;
          // The result is the RS value before any load on the completing edge
          if (completed) begin
            out_data_q  <= rs_q;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          ctrl_clr_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_expr_datapath.sv
// Testbench for expr_datapath: the bench plays the sequencer, issuing micro-op
// programs and comparing results against an arithmetic model through a scoreboard.
module tb_expr_datapath;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] a_in, b_in, c_in, x_in;
  logic         start;
  logic         LX, LS, LH, H;
  logic [1:0]   M0, M1, M2;
  logic         completed, ctrl_clr;
  logic [W-1:0] out_data;
  logic         out_valid, out_ready;

  typedef struct packed {
    logic       lx, ls, lh, h;
    logic [1:0] m0, m1, m2;
  } op_t;

  op_t          prog[$];
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  longint unsigned m_a, m_b, m_c, m_x, m_rx, m_rs, m_rh;

  expr_datapath #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .x_in(x_in), .start(start),
    .LX(LX), .LS(LS), .LH(LH), .H(H), .M0(M0), .M1(M1), .M2(M2),
    .completed(completed), .ctrl_clr(ctrl_clr), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic op_t mk(input logic lx, input logic ls, input logic lh, input logic h,
                             input logic [1:0] m0, input logic [1:0] m1, input logic [1:0] m2);
    op_t o;
    o.lx = lx; o.ls = ls; o.lh = lh; o.h = h; o.m0 = m0; o.m1 = m1; o.m2 = m2;
    return o;
  endfunction

  function automatic op_t rnd_op();
    logic [9:0] rv;
    rv = 10'($urandom);
    return rv;
  endfunction

  task automatic drive_op(input op_t o);
    LX = o.lx; LS = o.ls; LH = o.lh; H = o.h; M0 = o.m0; M1 = o.m1; M2 = o.m2;
  endtask

  // Reference: coefficient/operand tables and modular arithmetic on wide integers
  function automatic void model_step(input op_t o);
    longint unsigned cf[4], sa[4], sb[4];
    longint unsigned k, p, q, r, modv;
    modv = 64'd1 << W;
    cf = '{64'd0, m_a, m_b, m_c};
    k  = cf[o.m0];
    sa = '{m_rs, m_rx, k, m_rh};
    sb = '{m_rx, k, m_rh, m_rs};
    p  = sa[o.m1];
    q  = sb[o.m2];
    r  = o.h ? (p * q) % modv : (p + q) % modv;
    if (o.lx) m_rx = m_x;
    if (o.ls) m_rs = r;
    if (o.lh) m_rh = r;
  endfunction

  // Scoreboard monitor: compares whenever a result handshake is about to complete
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result_unexpected: got %0h, expected no result", out_data);
      end else begin
        check("result", out_data, exp_q.pop_front());
      end
    end
  end

  // Starts and ends #1 after a rising edge, in IDLE with completed low.
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic [W-1:0] x, input int wait_cyc, input bit noise,
                         input bit use_fixed, input logic [W-1:0] fixed, input int rst_after);
    logic [W-1:0] exp;
    op_t fo;
    a_in = a; b_in = b; c_in = c; x_in = x; in_valid = 1'b1;
    m_a = a; m_b = b; m_c = c; m_x = x; m_rx = 0; m_rs = 0; m_rh = 0;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = noise;
    a_in = W'($urandom); b_in = W'($urandom); c_in = W'($urandom); x_in = W'($urandom);
    @(negedge clk);
    check("start_pulse", start, 1);
    check("in_ready_after_capture", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("start_single", start, 0);
    for (int i = 0; i < prog.size(); i++) begin
      if (i == rst_after) begin
        drive_op(mk(0, 0, 0, 0, 0, 0, 0));
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_start", start, 0);
        check("rst_mid_ctrl_clr", ctrl_clr, 0);
        check("rst_mid_out_data", out_data, 0);
        check("rst_mid_in_ready", in_ready, 1);
        @(posedge clk); #1;
        return;
      end
      drive_op(prog[i]);
      model_step(prog[i]);
      @(posedge clk); #1;
    end
    fo  = rnd_op();
    exp = use_fixed ? fixed : W'(m_rs);
    drive_op(fo);
    model_step(fo);
    completed = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    drive_op(rnd_op());
    @(negedge clk);
    check("out_valid_rise", out_valid, 1);
    check("out_data_latched", out_data, exp);
    check("in_ready_done", in_ready, 0);
    @(posedge clk); #1;
    for (int i = 0; i < wait_cyc; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, exp);
      check("hold_no_clr", ctrl_clr, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("out_valid_fall", out_valid, 0);
    check("ctrl_clr_pulse", ctrl_clr, 1);
    check("in_ready_completed_high", in_ready, 0);
    @(posedge clk); #1;
    completed = 1'b0;
    in_valid  = 1'b0;
    drive_op(mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("ctrl_clr_single", ctrl_clr, 0);
    check("in_ready_back", in_ready, 1);
    check("no_start_idle", start, 0);
    @(posedge clk); #1;
  endtask

  task automatic load_directed();
    prog.delete();
    prog.push_back(mk(1, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    prog.push_back(mk(0, 1, 0, 1, 2'b01, 2'b10, 2'b00));
    prog.push_back(mk(0, 1, 0, 0, 2'b10, 2'b00, 2'b01));
    prog.push_back(mk(0, 0, 1, 1, 2'b00, 2'b00, 2'b00));
    prog.push_back(mk(0, 1, 0, 0, 2'b11, 2'b11, 2'b01));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; out_ready = 1'b0; completed = 1'b0; in_valid = 1'b0;
    a_in = '0; b_in = '0; c_in = '0; x_in = '0;
    drive_op(mk(0, 0, 0, 0, 0, 0, 0));
    repeat (2) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom); completed = 1'($urandom); out_ready = 1'($urandom);
      a_in = W'($urandom); b_in = W'($urandom); c_in = W'($urandom); x_in = W'($urandom);
      drive_op(rnd_op());
    end
    in_valid = 1'b0; completed = 1'b0; out_ready = 1'b0;
    drive_op(mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_start", start, 0);
    check("reset_ctrl_clr", ctrl_clr, 0);
    check("reset_out_data", out_data, 0);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;

    load_directed();
    run_txn(16'd2, 16'd5, 16'd7, 16'd3, 5, 1'b1, 1'b1, 16'd40, -1);

    prog.delete();
    prog.push_back(mk(1, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    prog.push_back(mk(0, 1, 0, 1, 2'b01, 2'b10, 2'b00));
    run_txn(16'h0100, 16'h0, 16'h0, 16'h0100, 0, 1'b0, 1'b1, 16'h0000, -1);

    prog.delete();
    prog.push_back(mk(1, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    prog.push_back(mk(0, 1, 0, 0, 2'b01, 2'b10, 2'b00));
    run_txn(16'hFFFF, 16'h0, 16'h0, 16'h0002, 1, 1'b0, 1'b1, 16'h0001, -1);

    load_directed();
    run_txn(16'd2, 16'd5, 16'd7, 16'd3, 0, 1'b0, 1'b0, 16'd0, 3);
    load_directed();
    run_txn(16'd2, 16'd5, 16'd7, 16'd3, 2, 1'b0, 1'b1, 16'd40, -1);

    for (int t = 0; t < 30; t++) begin
      int n;
      n = $urandom_range(0, 8);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back(rnd_op());
      run_txn(W'($urandom), W'($urandom), W'($urandom_range(0, 40)), W'($urandom),
              $urandom_range(0, 4), 1'($urandom), 1'b0, 16'd0, -1);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
